// File: rtl/cntry_car_sensor_filter.sv
// Country-road loop detector conditioner: synchronise, debounce, hold-stretch,
// stuck-sensor detection and a saturating arrival count.
module cntry_car_sensor_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       sensor_raw,
  output logic       car_on_cntry_rd,
  output logic       sensor_fault,
  output logic [7:0] car_count
);

  typedef enum logic [2:0] {IDLE, QUALIFY, PRESENT, HOLD, FAULT} state_t;

  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES);
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

  state_t      state, state_nx;
  logic        s1, s2, sensor_sync;
  logic [7:0]  qcnt, qcnt_nx, hcnt, hcnt_nx, count_nx, count_inc;
  logic [15:0] scnt, scnt_nx;

  assign sensor_sync = s2;
  assign count_inc   = (car_count == 8'hFF) ? car_count : car_count + 8'd1;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor_raw;
      s2 <= s1;
    end
  end

  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    hcnt_nx  = hcnt;
    scnt_nx  = scnt;
    count_nx = car_count;
    case (state)
      IDLE: begin
        qcnt_nx = 8'd0;
        if (sensor_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = PRESENT;
            scnt_nx  = 16'd0;
            count_nx = count_inc;
          end else begin
            state_nx = QUALIFY;
            qcnt_nx  = 8'd1;
          end
        end
      end
      QUALIFY: begin
        if (!sensor_sync) begin
          state_nx = IDLE;
          qcnt_nx  = 8'd0;
        end else if (qcnt == DEB_LAST) begin
          state_nx = PRESENT;
          qcnt_nx  = 8'd0;
          scnt_nx  = 16'd0;
          count_nx = count_inc;
        end else begin
          qcnt_nx = qcnt + 8'd1;
        end
      end
      PRESENT: begin
        if (!sensor_sync) begin
          state_nx = HOLD;
          hcnt_nx  = 8'd1;
          scnt_nx  = 16'd0;
        end else if (scnt == STUCK_LAST) begin
          state_nx = FAULT;
          qcnt_nx  = 8'd0;
          scnt_nx  = 16'd0;
        end else begin
          scnt_nx = scnt + 16'd1;
        end
      end
      HOLD: begin
        // A returning car resumes presence without being counted again.
        if (sensor_sync) begin
          state_nx = PRESENT;
          scnt_nx  = 16'd0;
          hcnt_nx  = 8'd0;
        end else if (hcnt == HOLD_LAST) begin
          state_nx = IDLE;
          hcnt_nx  = 8'd0;
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      FAULT: begin
        // Leave only after DEBOUNCE_CYCLES consecutive low samples.
        if (sensor_sync) begin
          qcnt_nx = 8'd0;
        end else if (qcnt == DEB_LAST) begin
          state_nx = IDLE;
          qcnt_nx  = 8'd0;
        end else begin
          qcnt_nx = qcnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        qcnt_nx  = 8'd0;
        hcnt_nx  = 8'd0;
        scnt_nx  = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state           <= IDLE;
      qcnt            <= 8'd0;
      hcnt            <= 8'd0;
      scnt            <= 16'd0;
      car_count       <= 8'd0;
      car_on_cntry_rd <= 1'b0;
      sensor_fault    <= 1'b0;
    end else begin
      state           <= state_nx;
      qcnt            <= qcnt_nx;
      hcnt            <= hcnt_nx;
      scnt            <= scnt_nx;
      car_count       <= count_nx;
      car_on_cntry_rd <= (state_nx == PRESENT) || (state_nx == HOLD);
      sensor_fault    <= (state_nx == FAULT);
    end
  end

endmodule
